// File: rtl/decode.sv
// Instruction-decode stage: field split, immediate sign extension and a
// 32 x 32-bit register file with two combinational read ports, one
// write port, and same-cycle write-through bypass.
//
// Handshake: there is no valid/ready pair here. The write port is a plain
// enable. When regWrite is high on a rising edge with rst low and writeReg
// non-zero, writeData is committed. The same qualified write is forwarded
// to the read ports in the cycle before that edge.
module decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        regWrite,
    input  logic [4:0]  writeReg,
    input  logic [31:0] writeData,
    output logic [5:0]  opCode,
    output logic [31:0] readData1,
    output logic [31:0] readData2,
    output logic [31:0] signExtendedImmidiate,
    output logic [4:0]  rt,
    output logic [4:0]  rd
);

    // R1..R31 are stored. R0 has no storage and always reads as zero.
    logic [31:0] rf_q [1:31];

    logic [4:0]  rs;
    logic        wr_en_d;
    logic [31:0] stored1;
    logic [31:0] stored2;

    // Field extraction is identical for every instruction format.
    always_comb begin
        opCode                = instruction[31:26];
        rs                    = instruction[25:21];
        rt                    = instruction[20:16];
        rd                    = instruction[15:11];
        signExtendedImmidiate = {{16{instruction[15]}}, instruction[15:0]};
    end

    // A write counts only when it is enabled, targets a real register,
    // and reset is not asserted. Reset takes priority over the write.
    always_comb begin
        wr_en_d = regWrite && !rst && (writeReg != 5'd0);
    end

    // Stored read values. Index 0 reads as zero.
    always_comb begin
        stored1 = 32'd0;
        stored2 = 32'd0;
        if (rs != 5'd0) stored1 = rf_q[rs];
        if (rt != 5'd0) stored2 = rf_q[rt];
    end

    // Read ports with write-through bypass from the pending write-back.
    always_comb begin
        readData1 = stored1;
        readData2 = stored2;
        if (wr_en_d && (writeReg == rs)) readData1 = writeData;
        if (wr_en_d && (writeReg == rt)) readData2 = writeData;
    end

    // Register file update: reset clears everything, otherwise commit the
    // qualified write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (wr_en_d) begin
            rf_q[writeReg] <= writeData;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage: field extraction, sign extension,
// register writes and reads, bypass, R0 behaviour and reset priority.
module tb_decode;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [5:0]  opCode;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] signExtendedImmidiate;
    logic [4:0]  rt;
    logic [4:0]  rd;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Reference register contents, updated by the driver tasks.
    logic [31:0] model_rf [32];
    logic [31:0] exp_q [$];

    decode dut (
        .clk                   (clk),
        .rst                   (rst),
        .instruction           (instruction),
        .regWrite              (regWrite),
        .writeReg              (writeReg),
        .writeData             (writeData),
        .opCode                (opCode),
        .readData1             (readData1),
        .readData2             (readData2),
        .signExtendedImmidiate (signExtendedImmidiate),
        .rt                    (rt),
        .rd                    (rd)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge, then let combinational paths settle.
    task automatic drive(input logic r, input logic [31:0] ins, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        rst         = r;
        instruction = ins;
        regWrite    = we;
        writeReg    = wa;
        writeData   = wd;
        #1;
    endtask

    // Let a rising edge pass and update the model as the register file should.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        end else if (regWrite && writeReg != 5'd0) begin
            model_rf[writeReg] = writeData;
        end
    endtask

    task automatic check_fields(input string tag, input logic [5:0] op, input logic [4:0] t,
                                input logic [4:0] d, input logic [31:0] imm);
        check_eq({tag, "_op"},  {26'd0, opCode}, {26'd0, op});
        check_eq({tag, "_rt"},  {27'd0, rt},     {27'd0, t});
        check_eq({tag, "_rd"},  {27'd0, rd},     {27'd0, d});
        check_eq({tag, "_imm"}, signExtendedImmidiate, imm);
    endtask

    // Read-port scoreboard: expected values from the model, in port order.
    task automatic check_reads_model(input string tag);
        logic [31:0] e;
        exp_q.push_back(model_rf[instruction[25:21]]);
        exp_q.push_back(model_rf[instruction[20:16]]);
        e = exp_q.pop_front();
        check_eq({tag, "_rd1"}, readData1, e);
        e = exp_q.pop_front();
        check_eq({tag, "_rd2"}, readData2, e);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model_rf[i] = 32'hxxxxxxxx;
        rst = 1'b1; instruction = 32'd0; regWrite = 1'b0; writeReg = 5'd0; writeData = 32'd0;

        // Reset for two edges.
        drive(1'b1, 32'h04430004, 1'b0, 5'd0, 32'd0);
        tick();
        tick();

        // I-type fields and post-reset reads.
        drive(1'b0, 32'h04430004, 1'b0, 5'd0, 32'd0);
        check_fields("itype", 6'd1, 5'd3, 5'd0, 32'h00000004);
        check_eq("reset_rd1", readData1, 32'd0);
        check_eq("reset_rd2", readData2, 32'd0);

        // R-type fields.
        drive(1'b0, 32'h1CB62C0A, 1'b0, 5'd0, 32'd0);
        check_fields("rtype", 6'd7, 5'd22, 5'd5, 32'h00002C0A);

        // Negative immediates.
        drive(1'b0, 32'h2001FFFF, 1'b0, 5'd0, 32'd0);
        check_eq("neg_imm_ffff", signExtendedImmidiate, 32'hFFFFFFFF);
        drive(1'b0, 32'h20018000, 1'b0, 5'd0, 32'd0);
        check_eq("neg_imm_8000", signExtendedImmidiate, 32'hFFFF8000);
        drive(1'b0, 32'h20017FFF, 1'b0, 5'd0, 32'd0);
        check_eq("pos_imm_7fff", signExtendedImmidiate, 32'h00007FFF);

        // Write R5 and R22 on consecutive edges, then read them back.
        drive(1'b0, 32'h04430004, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        drive(1'b0, 32'h04430004, 1'b1, 5'd22, 32'h12345678);
        tick();
        drive(1'b0, 32'h1CB62C0A, 1'b0, 5'd0, 32'd0);
        check_eq("wr_rd1", readData1, 32'hDEADBEEF);
        check_eq("wr_rd2", readData2, 32'h12345678);
        check_reads_model("wr_model");

        // Bypass on rs before the edge, rt unaffected.
        drive(1'b0, 32'h1CB62C0A, 1'b1, 5'd5, 32'hA5A5A5A5);
        check_eq("byp_rs_rd1", readData1, 32'hA5A5A5A5);
        check_eq("byp_rs_rd2", readData2, 32'h12345678);
        tick();
        drive(1'b0, 32'h1CB62C0A, 1'b0, 5'd0, 32'd0);
        check_eq("byp_rs_after", readData1, 32'hA5A5A5A5);

        // Bypass on rt before the edge.
        drive(1'b0, 32'h1CB62C0A, 1'b1, 5'd22, 32'h0BADF00D);
        check_eq("byp_rt_rd2", readData2, 32'h0BADF00D);
        check_eq("byp_rt_rd1", readData1, 32'hA5A5A5A5);
        tick();
        drive(1'b0, 32'h1CB62C0A, 1'b0, 5'd0, 32'd0);
        check_reads_model("byp_rt_after");

        // Writes to R0 are ignored, with no bypass either.
        drive(1'b0, 32'h2001FFFF, 1'b1, 5'd0, 32'hFFFFFFFF);
        check_eq("r0_byp_rd1", readData1, 32'd0);
        tick();
        drive(1'b0, 32'h2001FFFF, 1'b0, 5'd0, 32'd0);
        check_eq("r0_after_rd1", readData1, 32'd0);

        // rs == rt returns the same value on both ports.
        drive(1'b0, 32'h00A50000, 1'b0, 5'd0, 32'd0);
        check_eq("same_rd1", readData1, 32'hA5A5A5A5);
        check_eq("same_rd2", readData2, 32'hA5A5A5A5);

        // Reset priority: load R3 and R5, then reset alongside a write to R3.
        drive(1'b0, 32'h00650000, 1'b1, 5'd3, 32'h00000055);
        tick();
        drive(1'b0, 32'h00650000, 1'b1, 5'd5, 32'h00000077);
        tick();
        drive(1'b0, 32'h00650000, 1'b0, 5'd0, 32'd0);
        check_eq("pre_rst_r3", readData1, 32'h00000055);
        check_eq("pre_rst_r5", readData2, 32'h00000077);
        drive(1'b1, 32'h00650000, 1'b1, 5'd3, 32'h00000099);
        check_eq("rst_nobyp_r3", readData1, 32'h00000055);
        tick();
        drive(1'b1, 32'h00650000, 1'b1, 5'd3, 32'h00000099);
        check_eq("rst_cyc_r3", readData1, 32'd0);
        check_eq("rst_cyc_r5", readData2, 32'd0);
        check_fields("rst_fields", 6'd0, 5'd5, 5'd0, 32'h00000000);
        tick();
        drive(1'b0, 32'h00650000, 1'b0, 5'd0, 32'd0);
        check_eq("post_rst_r3", readData1, 32'd0);
        check_eq("post_rst_r5", readData2, 32'd0);
        check_reads_model("post_rst_model");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/decode.md
# decode

Instruction-decode stage of the single-clock MIPS datapath. It splits a 32-bit instruction into its fields and sign-extends the 16-bit immediate. It also holds the 32 x 32-bit general-purpose register file. Two source registers (rs, rt) are read combinationally, and one register is written per clock from the write-back stage.

## Interface
Parameters: none (widths fixed: 32-bit data, 32 registers, 5-bit register index).

- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset; clears register file
- instruction  input  32  instruction word from fetch
- regWrite  input  1  write enable from write-back
- writeReg  input  5  destination register index for write-back
- writeData  input  32  data to write
- opCode  output  6  instruction[31:26]
- readData1  output  32  contents of register rs = instruction[25:21]
- readData2  output  32  contents of register rt = instruction[20:16]
- signExtendedImmidiate  output  32  instruction[15:0] sign-extended
- rt  output  5  instruction[20:16]
- rd  output  5  instruction[15:11]

## Operation
- Field extraction is purely combinational and is the same for every format (R/I/J). No opcode-dependent muxing.
  - opCode = instruction[31:26], rt = instruction[20:16], rd = instruction[15:11].
  - signExtendedImmidiate = {16{instruction[15]}, instruction[15:0]}.
- Register file: 32 x 32-bit entries, R0 through R31.
  - R0 is hardwired to 0. Writes to index 0 are ignored and reads of index 0 always return 0.
- Write: on a rising clk edge, with rst=0 and regWrite=1 and writeReg != 0, R[writeReg] <= writeData.
- Reads are combinational.
  - readData1 = R[rs], readData2 = R[rt].
- Write-through bypass:
  - If regWrite=1, rst=0, writeReg != 0 and writeReg == rs, then readData1 = writeData in the same cycle.
  - The same rule applies to readData2 when writeReg == rt.
  - A same-cycle write-back is therefore visible to the instruction being decoded.
- Reset: on a rising clk edge with rst=1, all 32 registers become 0x00000000.
  - Reset has priority over a simultaneous write, so the write is dropped.
  - Bypass is disabled while rst=1, so readData1/2 reflect stored contents only.
- Instruction X/undefined: outputs may be X. No sanitizing is required.

## Timing
- Field outputs and the immediate have zero latency (combinational from instruction).
- readData1/2 have zero latency from instruction, register contents and the bypass inputs.
- Register writes commit at the rising edge. Without bypass, the new value would appear on read ports in the cycle after the edge. With bypass, it also appears in the cycle before the edge.
- After a reset edge, every register reads 0.
  - readData1 = readData2 = 0 for any instruction until a write occurs.
  - opCode, rt, rd and signExtendedImmidiate follow instruction and are unaffected by rst.
- Reset asserted mid-operation: the current cycle's pending write is discarded, and all prior contents are lost at that edge.
- Simultaneous read and write of the same register: covered by the bypass rule.
- rs == rt: both ports return the same value.

## Test plan
- I-type fields: instruction=0x04430004 -> opCode=6'd1, rt=5'd3, rd=5'd0, signExtendedImmidiate=0x00000004. After reset, readData1=readData2=0.
- R-type fields: instruction=0x1CB62C0A -> opCode=6'd7, rt=5'd22, rd=5'd5, signExtendedImmidiate=0x00002C0A. Register reads use rs=5 and rt=22.
- Negative immediate: instruction=0x2001FFFF -> signExtendedImmidiate=0xFFFFFFFF. With instruction=0x20018000 -> signExtendedImmidiate=0xFFFF8000.
- Write then read:
  - Write R5=0xDEADBEEF and R22=0x12345678 on consecutive edges (regWrite=1), then deassert regWrite.
  - Apply 0x1CB62C0A -> readData1=0xDEADBEEF, readData2=0x12345678.
- Bypass and R0:
  - With instruction rs=5 and regWrite=1, writeReg=5, writeData=0xA5A5A5A5 -> readData1=0xA5A5A5A5 before the edge.
  - Write writeReg=0, writeData=0xFFFFFFFF, then read rs=0 -> readData1=0.
- Reset priority:
  - Load R3=0x55 and R5=0x77.
  - Assert rst=1 together with regWrite=1, writeReg=3, writeData=0x99 for one edge.
  - Afterwards R3 and R5 both read 0, and readData shows 0 during the rst cycle, with no bypass.
